cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// - Shares the single Common Data Bus between NUM_REQ result producers (ALU, mult, load unit, ...).
// - Holds one completed result per producer in a 1-entry slot and picks one slot per cycle, round-robin.
// - Drives a registered CDB_DATA broadcast consumed by the ROB, the reservation stations and the map table.
// PARAMETERS
// - NUM_REQ  4  number of producers; must be >= 2; need not be a power of 2
// PORTS
// - clock        in   1                     system clock; all state updates on posedge
// - reset        in   1                     synchronous, active-high; clears all state
// - req_valid    in   [NUM_REQ]             producer i presents a completed result
// - req_rob_tag  in   [NUM_REQ][ROB_TAG_LEN] ROB tag of producer i's result
// - req_value    in   [NUM_REQ][XLEN]        result value (or store address) of producer i
// - req_ready    out  [NUM_REQ]             slot i can accept this cycle
// - cdb_data     out  CDB_DATA              registered broadcast {valid, rob_tag, value}
// - grant        out  [NUM_REQ]             one-hot slot chosen this cycle (combinational, debug)
// - busy         out  1                     any slot full
// BEHAVIOUR
// - Clock and reset: one clock; reset is synchronous and active-high.
// - State
//   - per slot: full[i], tag[i], value[i]
//   - rr_ptr: width $clog2(NUM_REQ)
//   - cdb_data register
// - Reset values
//   - all full[i]=0; rr_ptr=0
//   - cdb_data = '{valid:0, rob_tag:0, value:0}
//   - req_ready all 1; grant 0; busy 0
//   - Reset beats any same-cycle accept; buffered results are dropped.
// - Arbitration (combinational)
//   - grant = first full slot searching circularly from rr_ptr upward.
//   - grant = 0 if no slot is full.
// - Pointer
//   - on any grant: rr_ptr <= (granted index == NUM_REQ-1) ? 0 : granted index + 1
//   - else rr_ptr holds.
// - CDB register
//   - on grant of slot g: cdb_data <= '{1, tag[g], value[g]}
//   - else cdb_data <= '{0, 0, 0}.
//   - A valid broadcast lasts exactly one cycle per grant.
// - Handshake
//   - req_ready[i] = !full[i] || grant[i]; never depends on req_valid.
//   - Accept when req_valid[i] && req_ready[i]: slot loads tag/value and full[i] <= 1.
//   - Producer must hold req_* stable until accepted.
// - Slot release
//   - grant[i] with no accept: full[i] <= 0.
//   - grant[i] with accept in the same cycle: slot reloads with the new data and stays full.
//     This gives a 1 result/cycle stream per producer when it is uncontended.
// - Latency
//   - result accepted at edge N into an empty, uncontended arbiter: granted in cycle N..N+1.
//   - cdb_data.valid is high after edge N+1.
//   - No bypass from req_* to cdb_data.
// - Throughput and fairness
//   - Exactly one broadcast per cycle while busy.
//   - A full slot is granted within NUM_REQ cycles.
// - Widths: tags and values pass through untouched. No arithmetic except the rr_ptr wrap.
// STRUCTURE
// - Shared package
//   - CDB_DATA typedef (existing)
//   - `XLEN, `ROB_TAG_LEN (existing)
//   - new `NUM_CDB_REQ default constant
// - Sub-module rr_pick
//   - purely combinational circular priority picker
//   - inputs: req vector, start pointer; outputs: one-hot grant, index, any
//   - reusable by the RS issue selector.
// - Top level holds the slot registers, rr_ptr and the cdb_data register.
// TESTING
// - Reset: hold reset 2 cycles with all req_valid=1 -> cdb_data.valid=0, req_ready=4'b1111, busy=0, no slot loaded.
// - Single: req0 tag=3 value=32'hDEAD accepted at edge 1
//   -> cdb_data='{1,3,DEAD} after edge 2 only; valid=0 after edge 3.
// - Contention: req0..3 tags 1..4 all valid at edge 1
//   -> broadcasts of tags 1,2,3,4 on 4 consecutive cycles.
//   -> req_ready[i] low until slot i is granted.
// - Fairness: req0 held continuously valid, req2 valid once
//   -> order 0,2,0,0...; slot 0 is never granted twice while slot 2 is full.
// - Streaming: req1 sends values 10,11,12 on consecutive cycles, other producers idle
//   -> req_ready[1] stays 1; CDB shows 10,11,12 back-to-back.
// - Reset mid-operation: slots 0,1,3 full, assert reset
//   -> next cycle cdb_data.valid=0, busy=0, rr_ptr=0.
//   -> a fresh req3 afterwards broadcasts after 2 edges.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and widths used by the result producers, the CDB arbiter and its consumers.
package cdb_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 6;
    localparam int NUM_CDB_REQ = 4;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [XLEN-1:0]        value;
    } cdb_data_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational circular priority picker: the first set request at or after start, wrapping at N.
module cdb_arbiter_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            // Wrap by subtraction so N does not have to be a power of two.
            pos = {1'b0, start} + (W+1)'(k);
            if (pos >= (W+1)'(N)) begin
                pos = pos - (W+1)'(N);
            end
            if (!any && req[pos[W-1:0]]) begin
                any             = 1'b1;
                idx             = pos[W-1:0];
                grant[pos[W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one result slot per producer, round-robin pick, registered broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_CDB_REQ
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0][ROB_TAG_LEN-1:0]   req_rob_tag,
    input  logic [NUM_REQ-1:0][XLEN-1:0]          req_value,
    output logic [NUM_REQ-1:0]                    req_ready,
    output cdb_data_t                             cdb_data,
    output logic [NUM_REQ-1:0]                    grant,
    output logic                                  busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]     full;
    logic [ROB_TAG_LEN-1:0] tag_q   [NUM_REQ];
    logic [XLEN-1:0]        value_q [NUM_REQ];
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [NUM_REQ-1:0]     accept;

    cdb_arbiter_rr_pick #(
        .N (NUM_REQ),
        .W (PTR_W)
    ) u_rr_pick (
        .req   (full),
        .start (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // A slot being granted this cycle can take a new result, giving 1 result/cycle per producer.
    assign req_ready = ~full | grant;
    assign accept    = req_valid & req_ready;
    assign busy      = |full;

    always_ff @(posedge clock) begin
        if (reset) begin
            full     <= '0;
            rr_ptr   <= '0;
            cdb_data <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                tag_q[i]   <= '0;
                value_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    full[i]    <= 1'b1;
                    tag_q[i]   <= req_rob_tag[i];
                    value_q[i] <= req_value[i];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end

            if (grant_any) begin
                rr_ptr   <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                cdb_data <= '{valid: 1'b1, rob_tag: tag_q[grant_idx], value: value_q[grant_idx]};
            end else begin
                cdb_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, contention, fairness, streaming, mid-run reset.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 4;

    logic                              clock;
    logic                              reset;
    logic [N-1:0]                      req_valid;
    logic [N-1:0][ROB_TAG_LEN-1:0]     req_rob_tag;
    logic [N-1:0][XLEN-1:0]            req_value;
    logic [N-1:0]                      req_ready;
    cdb_data_t                         cdb_data;
    logic [N-1:0]                      grant;
    logic                              busy;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_rob_tag (req_rob_tag),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .cdb_data    (cdb_data),
        .grant       (grant),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_rob_tag = '0;
        req_value   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        req_valid   = '1;
        req_rob_tag = {6'd4, 6'd3, 6'd2, 6'd1};
        req_value   = {32'h44, 32'h33, 32'h22, 32'h11};
        tick();
        tick();
        n_checks++;
        if (cdb_data.valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %0b want 0", cdb_data.valid);
        end
        n_checks++;
        if (req_ready !== 4'b1111) begin
            n_fail++; $display("FAIL reset_ready got %b want 1111", req_ready);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %0b want 0", busy);
        end
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++; $display("FAIL reset_grant got %b want 0000", grant);
        end
        clear_inputs();
        reset = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || cdb_data.valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_load busy %0b valid %0b want 0 0", busy, cdb_data.valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid[0]   = 1'b1;
        req_rob_tag[0] = 6'd3;
        req_value[0]   = 32'hDEAD;
        tick();
        clear_inputs();
        n_checks++;
        if (cdb_data.valid !== 1'b0) begin
            n_fail++; $display("FAIL single_edge1_valid got %0b want 0", cdb_data.valid);
        end
        n_checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_grant got %b busy %0b want 0001 1", grant, busy);
        end
        tick();
        n_checks++;
        if (cdb_data !== '{valid: 1'b1, rob_tag: 6'd3, value: 32'hDEAD}) begin
            n_fail++; $display("FAIL single_bcast got %0b/%0d/%h want 1/3/dead",
                               cdb_data.valid, cdb_data.rob_tag, cdb_data.value);
        end
        tick();
        n_checks++;
        if (cdb_data.valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_edge3 valid %0b busy %0b want 0 0", cdb_data.valid, busy);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_ready;
        do_reset();
        req_valid   = '1;
        req_rob_tag = {6'd4, 6'd3, 6'd2, 6'd1};
        req_value   = {32'h103, 32'h102, 32'h101, 32'h100};
        tick();
        clear_inputs();
        n_checks++;
        if (req_ready !== 4'b0001 || cdb_data.valid !== 1'b0) begin
            n_fail++; $display("FAIL cont_edge1 ready %b valid %0b want 0001 0", req_ready, cdb_data.valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (cdb_data !== '{valid: 1'b1, rob_tag: 6'(k + 1), value: 32'(32'h100 + k)}) begin
                n_fail++; $display("FAIL cont_bcast%0d got %0b/%0d/%h want 1/%0d/%h", k,
                                   cdb_data.valid, cdb_data.rob_tag, cdb_data.value, k + 1, 32'h100 + k);
            end
            exp_ready = 4'((1 << (k + 2)) - 1);
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++; $display("FAIL cont_ready%0d got %b want %b", k, req_ready, exp_ready);
            end
        end
        tick();
        n_checks++;
        if (cdb_data.valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cont_drain valid %0b busy %0b want 0 0", cdb_data.valid, busy);
        end
    endtask

    task automatic test_fairness();
        logic [5:0] exp_tag [4];
        logic [5:0] cur_tag;
        logic       rdy0;
        exp_tag = '{6'd10, 6'd20, 6'd11, 6'd12};
        do_reset();
        cur_tag        = 6'd10;
        req_valid      = 4'b0101;
        req_rob_tag[0] = cur_tag;
        req_value[0]   = 32'd10;
        req_rob_tag[2] = 6'd20;
        req_value[2]   = 32'd20;
        rdy0 = req_ready[0];
        tick();
        req_valid[2] = 1'b0;
        if (rdy0) begin
            cur_tag        = cur_tag + 1'b1;
            req_rob_tag[0] = cur_tag;
            req_value[0]   = 32'(cur_tag);
        end
        for (int k = 0; k < 4; k++) begin
            rdy0 = req_ready[0];
            tick();
            n_checks++;
            if (cdb_data.valid !== 1'b1 || cdb_data.rob_tag !== exp_tag[k]) begin
                n_fail++; $display("FAIL fair_order%0d got %0b/%0d want 1/%0d", k,
                                   cdb_data.valid, cdb_data.rob_tag, exp_tag[k]);
            end
            if (k == 0) begin
                n_checks++;
                if (grant !== 4'b0100 || req_ready[0] !== 1'b0) begin
                    n_fail++; $display("FAIL fair_slot2_next grant %b ready0 %0b want 0100 0",
                                       grant, req_ready[0]);
                end
            end
            if (rdy0) begin
                cur_tag        = cur_tag + 1'b1;
                req_rob_tag[0] = cur_tag;
                req_value[0]   = 32'(cur_tag);
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_streaming();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req_valid[1] = 1'b1;
            req_value[1] = 32'(10 + k);
            req_rob_tag[1] = 6'(k + 1);
            n_checks++;
            if (req_ready[1] !== 1'b1) begin
                n_fail++; $display("FAIL stream_ready%0d got %0b want 1", k, req_ready[1]);
            end
            tick();
            if (k > 0) begin
                n_checks++;
                if (cdb_data.valid !== 1'b1 || cdb_data.value !== 32'(10 + k - 1)) begin
                    n_fail++; $display("FAIL stream_bcast%0d got %0b/%0d want 1/%0d", k - 1,
                                       cdb_data.valid, cdb_data.value, 10 + k - 1);
                end
            end
        end
        clear_inputs();
        tick();
        n_checks++;
        if (cdb_data.valid !== 1'b1 || cdb_data.value !== 32'd12 || cdb_data.rob_tag !== 6'd3) begin
            n_fail++; $display("FAIL stream_bcast2 got %0b/%0d/%0d want 1/12/3",
                               cdb_data.valid, cdb_data.value, cdb_data.rob_tag);
        end
        tick();
        n_checks++;
        if (cdb_data.valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_end got %0b want 0", cdb_data.valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid   = 4'b1011;
        req_rob_tag = {6'd33, 6'd0, 6'd31, 6'd30};
        req_value   = {32'h333, 32'h0, 32'h311, 32'h300};
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (busy !== 1'b1 || grant !== 4'b0010) begin
            n_fail++; $display("FAIL mid_pre busy %0b grant %b want 1 0010", busy, grant);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (cdb_data.valid !== 1'b0 || busy !== 1'b0 || dut.rr_ptr !== 2'd0) begin
            n_fail++; $display("FAIL mid_reset valid %0b busy %0b ptr %0d want 0 0 0",
                               cdb_data.valid, busy, dut.rr_ptr);
        end
        req_valid[3]   = 1'b1;
        req_rob_tag[3] = 6'd17;
        req_value[3]   = 32'hBEEF;
        tick();
        clear_inputs();
        n_checks++;
        if (cdb_data.valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_fresh_early got %0b want 0", cdb_data.valid);
        end
        tick();
        n_checks++;
        if (cdb_data !== '{valid: 1'b1, rob_tag: 6'd17, value: 32'hBEEF}) begin
            n_fail++; $display("FAIL mid_fresh_bcast got %0b/%0d/%h want 1/17/beef",
                               cdb_data.valid, cdb_data.rob_tag, cdb_data.value);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_streaming();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
